// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: queues fetch-time predictions, checks them against
// EX resolution, and issues redirect/flush plus predictor-update strobes.
module branch_redirect_ctrl #(
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       F_push,
  input  logic       F_BP_taken,
  input  logic [4:0] F_BP_target_pc,
  input  logic       EX_brn,
  input  logic [4:0] EX_pc,
  input  logic [4:0] EX_alu_out,
  input  logic       EX_true_taken,
  output logic       redirect_valid,
  output logic [4:0] redirect_pc,
  output logic       flush,
  output logic       bp_upd_en,
  output logic       q_full,
  output logic       q_overflow,
  output logic [7:0] br_count,
  output logic [7:0] mp_count
);

  // state | meaning
  // RUN   | normal operation: push/pop records, compare predictions
  // FLUSH | squashing F/D after a mispredict; push/pop/counts ignored
  typedef enum logic {RUN, FLUSH} state_t;

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [2:0]    fcnt_q, fcnt_d;
  logic [7:0]    br_q, br_d;
  logic [7:0]    mp_q, mp_d;
  logic          ovf_q, ovf_d;
  logic [5:0]    mem_q [QDEPTH];

  logic       run, empty, full, pop, do_pop, push_ok, mispred;
  logic       pred_taken;
  logic [4:0] pred_tgt, pc_inc;
  logic [5:0] head;

  assign run        = (state_q == RUN);
  assign empty      = (occ_q == '0);
  assign full       = (occ_q == CW'(QDEPTH));
  assign pc_inc     = EX_pc + 5'd1;
  assign head       = mem_q[rd_ptr_q];
  // An empty queue behaves as a not-taken prediction to the fall-through PC.
  assign pred_taken = empty ? 1'b0 : head[5];
  assign pred_tgt   = empty ? pc_inc : head[4:0];
  assign pop        = run & EX_brn;
  assign do_pop     = pop & ~empty;
  assign push_ok    = run & F_push & (~full | pop);
  assign mispred    = pop & ((pred_taken != EX_true_taken) |
                             (pred_taken & (pred_tgt != EX_alu_out)));

  assign redirect_valid = rst_n & mispred;
  assign redirect_pc    = EX_true_taken ? EX_alu_out : pc_inc;
  assign flush          = rst_n & (~run | mispred);
  assign bp_upd_en      = rst_n & pop;
  assign q_full         = rst_n & full;
  assign q_overflow     = ovf_q;
  assign br_count       = br_q;
  assign mp_count       = mp_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    fcnt_d   = fcnt_q;
    br_d     = br_q;
    mp_d     = mp_q;
    ovf_d    = ovf_q | (run & F_push & full & ~pop);
    if (pop && br_q != 8'd255) br_d = br_q + 8'd1;
    if (run) begin
      if (mispred) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        occ_d    = '0;
        fcnt_d   = 3'(FLUSH_CYCLES - 1);
        state_d  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        if (mp_q != 8'd255) mp_d = mp_q + 8'd1;
      end else begin
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, do_pop})
          2'b10:   occ_d = occ_q + CW'(1);
          2'b01:   occ_d = occ_q - CW'(1);
          default: occ_d = occ_q;
        endcase
      end
    end else begin
      // The mispredict cycle itself is the first flush cycle.
      if (fcnt_q <= 3'd1) begin
        fcnt_d  = 3'd0;
        state_d = RUN;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      fcnt_q   <= '0;
      br_q     <= '0;
      mp_q     <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      fcnt_q   <= fcnt_d;
      br_q     <= br_d;
      mp_q     <= mp_d;
      ovf_q    <= ovf_d;
      if (push_ok && !mispred) mem_q[wr_ptr_q] <= {F_BP_taken, F_BP_target_pc};
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, hand sequences for
// reset-in-flush, then randomized traffic against a queue-based reference model.
module tb_branch_redirect_ctrl;
  localparam int QD = 4;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       F_push, F_BP_taken, EX_brn, EX_true_taken;
  logic [4:0] F_BP_target_pc, EX_pc, EX_alu_out;
  logic       redirect_valid, flush, bp_upd_en, q_full, q_overflow;
  logic [4:0] redirect_pc;
  logic [7:0] br_count, mp_count;

  branch_redirect_ctrl #(.QDEPTH(QD), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_push(F_push), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc),
    .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_alu_out(EX_alu_out), .EX_true_taken(EX_true_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .bp_upd_en(bp_upd_en), .q_full(q_full), .q_overflow(q_overflow),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic tk, input logic [4:0] tg,
                       input logic b, input logic [4:0] pc, input logic [4:0] al,
                       input logic t);
    @(negedge clk);
    F_push = p; F_BP_taken = tk; F_BP_target_pc = tg;
    EX_brn = b; EX_pc = pc; EX_alu_out = al; EX_true_taken = t;
    #1;
  endtask

  typedef struct {
    logic push, ptk; logic [4:0] ptgt;
    logic brn; logic [4:0] pc, alu; logic tt;
    logic rv; logic [4:0] rpc; logic fl, upd, full;
    int br, mp; logic ovf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic push, ptk, input logic [4:0] ptgt,
                             input logic brn, input logic [4:0] pc, alu, input logic tt,
                             input logic rv, input logic [4:0] rpc, input logic fl, upd, full,
                             input int br, mp, input logic ovf);
    vec_t r;
    r.push = push; r.ptk = ptk; r.ptgt = ptgt; r.brn = brn; r.pc = pc; r.alu = alu;
    r.tt = tt; r.rv = rv; r.rpc = rpc; r.fl = fl; r.upd = upd; r.full = full;
    r.br = br; r.mp = mp; r.ovf = ovf;
    return r;
  endfunction

  // Reference model: queue of prediction records plus remaining flush-state cycles.
  typedef struct packed { logic tk; logic [4:0] tg; } rec_t;
  rec_t mq[$];
  int   m_fl, m_br, m_mp;
  bit   m_ovf;

  task automatic model_reset();
    mq.delete(); m_fl = 0; m_br = 0; m_mp = 0; m_ovf = 0;
  endtask

  task automatic model_step(input string tag);
    rec_t pr; logic [4:0] inc; bit mpd, e_rv, e_fl, e_upd, e_full, was_full;
    inc    = EX_pc + 5'd1;
    e_full = (mq.size() == QD);
    e_fl   = (m_fl > 0);
    e_rv = 0; e_upd = 0; mpd = 0;
    if (m_fl == 0 && EX_brn) begin
      pr    = (mq.size() > 0) ? mq[0] : {1'b0, inc};
      mpd   = (pr.tk != EX_true_taken) || (pr.tk && pr.tg != EX_alu_out);
      e_rv  = mpd; e_fl = mpd; e_upd = 1;
    end
    chk({tag, " redirect_valid"}, int'(redirect_valid), int'(e_rv));
    chk({tag, " flush"}, int'(flush), int'(e_fl));
    chk({tag, " bp_upd_en"}, int'(bp_upd_en), int'(e_upd));
    chk({tag, " q_full"}, int'(q_full), int'(e_full));
    chk({tag, " q_overflow"}, int'(q_overflow), int'(m_ovf));
    chk({tag, " br_count"}, int'(br_count), m_br);
    chk({tag, " mp_count"}, int'(mp_count), m_mp);
    if (e_rv) chk({tag, " redirect_pc"}, int'(redirect_pc), int'(EX_true_taken ? EX_alu_out : inc));
    if (m_fl > 0) m_fl--;
    else begin
      if (EX_brn && m_br < 255) m_br++;
      if (mpd) begin
        mq.delete();
        if (m_mp < 255) m_mp++;
        m_fl = FC - 1;
      end else begin
        was_full = (mq.size() == QD);
        if (EX_brn && mq.size() > 0) void'(mq.pop_front());
        if (F_push) begin
          if (!was_full || EX_brn) mq.push_back({F_BP_taken, F_BP_target_pc});
          else m_ovf = 1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    F_push = 0; F_BP_taken = 0; F_BP_target_pc = 0;
    EX_brn = 0; EX_pc = 0; EX_alu_out = 0; EX_true_taken = 0;
    #12;
    chk("reset flush", int'(flush), 0);
    chk("reset q_full", int'(q_full), 0);
    chk("reset br_count", int'(br_count), 0);
    chk("reset q_overflow", int'(q_overflow), 0);
    @(negedge clk); rst_n = 1'b1;

    //          push ptk tgt brn pc  alu tt | rv rpc fl upd full br mp ovf
    tbl.push_back(v(1, 1, 12, 0,  0,  0, 0,  0,  0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(v(0, 0,  0, 1,  4, 12, 1,  0,  0, 0, 1, 0,  0, 0, 0));
    tbl.push_back(v(0, 0,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(v(1, 1, 12, 0,  0,  0, 0,  0,  0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(v(0, 0,  0, 1,  4, 14, 1,  1, 14, 1, 1, 0,  1, 0, 0));
    tbl.push_back(v(0, 0,  0, 0,  0,  0, 0,  0,  0, 1, 0, 0,  2, 1, 0));
    tbl.push_back(v(0, 0,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0,  2, 1, 0));
    tbl.push_back(v(0, 0,  0, 1, 31,  0, 0,  0,  0, 0, 1, 0,  2, 1, 0));
    tbl.push_back(v(0, 0,  0, 1, 31,  3, 1,  1,  3, 1, 1, 0,  3, 1, 0));
    tbl.push_back(v(1, 1,  9, 1,  2,  9, 1,  0,  0, 1, 0, 0,  4, 2, 0));
    tbl.push_back(v(0, 0,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0,  4, 2, 0));
    tbl.push_back(v(1, 0,  1, 0,  0,  0, 0,  0,  0, 0, 0, 0,  4, 2, 0));
    tbl.push_back(v(1, 1,  2, 0,  0,  0, 0,  0,  0, 0, 0, 0,  4, 2, 0));
    tbl.push_back(v(1, 0,  3, 0,  0,  0, 0,  0,  0, 0, 0, 0,  4, 2, 0));
    tbl.push_back(v(1, 1,  4, 0,  0,  0, 0,  0,  0, 0, 0, 0,  4, 2, 0));
    tbl.push_back(v(1, 1,  5, 0,  0,  0, 0,  0,  0, 0, 0, 1,  4, 2, 0));
    tbl.push_back(v(1, 0,  6, 1,  0,  0, 0,  0,  0, 0, 1, 1,  4, 2, 1));
    tbl.push_back(v(0, 0,  0, 1,  1,  2, 1,  0,  0, 0, 1, 1,  5, 2, 1));
    tbl.push_back(v(0, 0,  0, 1,  2,  0, 0,  0,  0, 0, 1, 0,  6, 2, 1));
    tbl.push_back(v(0, 0,  0, 1,  3,  4, 1,  0,  0, 0, 1, 0,  7, 2, 1));
    tbl.push_back(v(0, 0,  0, 1,  5,  0, 0,  0,  0, 0, 1, 0,  8, 2, 1));
    tbl.push_back(v(0, 0,  0, 1,  9,  0, 0,  0,  0, 0, 1, 0,  9, 2, 1));
    tbl.push_back(v(0, 0,  0, 0,  0,  0, 0,  0,  0, 0, 0, 0, 10, 2, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].push, tbl[i].ptk, tbl[i].ptgt, tbl[i].brn, tbl[i].pc, tbl[i].alu, tbl[i].tt);
      chk($sformatf("v%0d redirect_valid", i), int'(redirect_valid), int'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("v%0d redirect_pc", i), int'(redirect_pc), int'(tbl[i].rpc));
      chk($sformatf("v%0d flush", i), int'(flush), int'(tbl[i].fl));
      chk($sformatf("v%0d bp_upd_en", i), int'(bp_upd_en), int'(tbl[i].upd));
      chk($sformatf("v%0d q_full", i), int'(q_full), int'(tbl[i].full));
      chk($sformatf("v%0d br_count", i), int'(br_count), tbl[i].br);
      chk($sformatf("v%0d mp_count", i), int'(mp_count), tbl[i].mp);
      chk($sformatf("v%0d q_overflow", i), int'(q_overflow), int'(tbl[i].ovf));
    end

    // Reset asserted while in FLUSH must drop flush immediately.
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("rstflush mispredict", int'(redirect_valid), 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("rstflush in flush", int'(flush), 1);
    rst_n = 1'b0;
    #1;
    chk("rstflush flush", int'(flush), 0);
    chk("rstflush bp_upd_en", int'(bp_upd_en), 0);
    chk("rstflush redirect", int'(redirect_valid), 0);
    chk("rstflush br_count", int'(br_count), 0);
    chk("rstflush mp_count", int'(mp_count), 0);
    chk("rstflush q_overflow", int'(q_overflow), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 1, 7, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 6, 7, 1);
    chk("postrst redirect", int'(redirect_valid), 0);
    chk("postrst bp_upd_en", int'(bp_upd_en), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("postrst br_count", int'(br_count), 1);

    // Randomized traffic against the model.
    @(negedge clk); rst_n = 1'b0;
    #1; rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic p, tk, b, t; logic [4:0] tg, pc, al; rec_t hd;
      p  = ($urandom_range(0, 9) < 6);
      tk = $urandom_range(0, 1);
      tg = 5'($urandom);
      b  = ($urandom_range(0, 9) < 5);
      pc = 5'($urandom);
      hd = (mq.size() > 0) ? mq[0] : {1'b0, 5'(pc + 5'd1)};
      t  = ($urandom_range(0, 3) == 0) ? ~hd.tk : hd.tk;
      al = ($urandom_range(0, 3) == 0) ? 5'($urandom) : hd.tg;
      drive(p, tk, tg, b, pc, al, t);
      model_step($sformatf("rnd%0d", c));
    end

    // 300 mispredicts on an empty queue: default not-taken vs resolved taken.
    for (int k = 0; k < 300; k++) begin
      drive(0, 0, 0, 1, 5'($urandom), 5'($urandom), 1);
      model_step($sformatf("sat%0d", k));
      drive(0, 0, 0, 0, 0, 0, 0);
      model_step($sformatf("satf%0d", k));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("sat mp_count", int'(mp_count), 255);
    chk("sat br_count", int'(br_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
